muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 The block SHALL provide the following ports, with clock and reset first:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  EX-stage instruction is mult/multu/div/divu; held high while stalled
- is_div  in  1  1 = divide, 0 = multiply; sampled on acceptance
- sgn  in  1  1 = signed (OPER_ALUS), 0 = unsigned (OPER_ALUU); sampled on acceptance
- opa  in  32  rs value, multiplicand or dividend
- opb  in  32  rt value, multiplier or divisor
- flush  in  1  exception or eret flush; aborts any operation
- hi_we  in  1  mthi write strobe
- lo_we  in  1  mtlo write strobe
- wdata  in  32  mthi/mtlo write data
- hi_o  out  32  architectural HI register
- lo_o  out  32  architectural LO register
- stall_o  out  1  pipeline hold request

Function
REQ-003 The block SHALL own the HI and LO registers.
REQ-004 hi_o and lo_o SHALL be driven directly from the HI and LO registers.
REQ-005 The block SHALL implement the states IDLE, RUN and FIX.
REQ-006 In IDLE with start=1 and flush=0, the block SHALL accept the operation.
- Latch |opa| and |opb| (magnitudes when sgn=1, raw when sgn=0), the result sign bits, is_div and sgn.
- Clear the 6-bit iteration counter.
- Go to RUN.
REQ-007 In RUN, the block SHALL perform one radix-2 step per cycle.
- Multiply: shift-add on a 64-bit accumulator.
- Divide: restoring shift-subtract producing a 32-bit quotient and a 32-bit remainder.
- The counter increments each cycle; after the 32nd step (counter = 31), go to FIX.
REQ-008 On acceptance of a divide with opb=0, the block SHALL go directly to FIX and leave HI and LO unchanged at commit.
REQ-009 In FIX, the block SHALL apply sign correction.
- Product: negated if sign(opa) XOR sign(opb), signed only.
- Quotient: negated if the signs differ.
- Remainder: takes the sign of the dividend.
REQ-010 At the FIX clock edge, the block SHALL commit the result and go to IDLE.
- Multiply: HI = product[63:32], LO = product[31:0].
- Divide: HI = remainder, LO = quotient.
REQ-011 While in FIX, start SHALL be ignored.
REQ-012 stall_o SHALL be combinational: stall_o = ~flush & ((IDLE & start) | RUN).
REQ-013 stall_o SHALL be 0 in FIX, so the pipeline advances on the same edge as the commit.
REQ-014 A multiply or nonzero divide SHALL stall for exactly 33 cycles: the acceptance cycle plus 32 RUN cycles.
REQ-015 A divide by zero SHALL stall for exactly 1 cycle.
REQ-016 The instruction immediately following SHALL see the committed HI/LO in its first EX cycle.
REQ-017 Signed arithmetic SHALL wrap modulo 2^32 per half.
- 0x80000000 / 0xFFFFFFFF (signed) gives LO=0x80000000, HI=0.
- 0x80000000 * 0x80000000 (signed) gives HI=0x40000000, LO=0.
REQ-018 hi_we and lo_we SHALL write wdata at the edge only when state=IDLE and start=0.
REQ-019 Strobes arriving while state is RUN or FIX SHALL be ignored.
REQ-020 hi_we and lo_we together SHALL write both HI and LO.
REQ-021 flush=1 in any state SHALL return the block to IDLE at the next edge and discard the operation.
- HI and LO remain unchanged.
- A flush in FIX takes priority over the commit.
- No acceptance occurs in that cycle.

Reset
REQ-022 rst=1 at an edge SHALL force state=IDLE, counter=0, HI=0 and LO=0, with priority over flush, start and the write strobes.
REQ-023 During rst, stall_o SHALL be 0.
REQ-024 Reset asserted mid-RUN SHALL abort the operation with no commit.
REQ-025 The first cycle after reset release SHALL accept start normally.

Verification
REQ-026 The bench SHALL cover the following directed scenarios:
- Unsigned multiply, opa=0xFFFFFFFF, opb=0xFFFFFFFF -> stall_o high 33 cycles, then HI=0xFFFFFFFE, LO=0x00000001.
- Signed divide, opa=-7 (0xFFFFFFF9), opb=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1), 33 stall cycles.
- Divide, opb=0, HI=0x11, LO=0x22 beforehand -> 1 stall cycle, then HI=0x11, LO=0x22.
- Flush asserted on the 10th RUN cycle of a multiply -> stall_o=0 in that cycle, IDLE next cycle, HI/LO unchanged.
- hi_we with wdata=0xDEAD during RUN is ignored; in IDLE it gives HI=0xDEAD on the next cycle.
- Back-to-back: multiply, then mflo on the cycle after FIX reads the new LO; a new start is accepted exactly 1 cycle after FIX.

Source files
------------

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_ctrl
// Description : Iterative radix-2 multiply/divide unit that owns HI/LO and
//               holds the pipeline while an operation is in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_div,
    input  logic        sgn,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic        flush,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stall_o
);

    localparam logic [5:0] c_LAST_STEP = 6'd31;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [5:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [63:0] r_acc;
    logic [31:0] r_b;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_is_div;
    logic        r_sgn;
    logic        r_dz;

    logic        w_accept;
    logic        w_wr_ok;
    logic        w_commit;

    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;

    logic [32:0] w_sum;
    logic [63:0] w_mul_nxt;
    logic [64:0] w_sh;
    logic [32:0] w_diff;
    logic [63:0] w_div_nxt;

    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    // Operand magnitudes; signs only matter for signed operations
    assign w_a_neg = sgn & opa[31];
    assign w_b_neg = sgn & opb[31];
    assign w_a_mag = w_a_neg ? (32'd0 - opa) : opa;
    assign w_b_mag = w_b_neg ? (32'd0 - opb) : opb;

    // Multiply step: multiplier sits in acc[31:0] and shifts out as the
    // partial product grows into the upper half.
    assign w_sum     = {1'b0, r_acc[63:32]} + {1'b0, r_b};
    assign w_mul_nxt = r_acc[0] ? {w_sum, r_acc[31:1]} : {1'b0, r_acc[63:1]};

    // Divide step: acc = {remainder, dividend/quotient}; restoring compare.
    assign w_sh      = {r_acc, 1'b0};
    assign w_diff    = w_sh[64:32] - {1'b0, r_b};
    assign w_div_nxt = w_diff[32] ? w_sh[63:0]
                                  : {w_diff[31:0], w_sh[31:1], 1'b1};

    assign w_prod = (r_sgn & r_neg_q) ? (64'd0 - r_acc) : r_acc;
    assign w_quo  = r_neg_q ? (32'd0 - r_acc[31:0])  : r_acc[31:0];
    assign w_rem  = r_neg_r ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_wr_ok     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!flush && start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (is_div && (opb == 32'd0)) ? S_FIX : S_RUN;
                end else if (!flush) begin
                    w_wr_ok = 1'b1;
                end
            end
            S_RUN: begin
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == c_LAST_STEP) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // A flush in FIX discards the result; divide-by-zero never commits.
    assign w_commit = (r_state == S_FIX) & ~flush & ~r_dz;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 6'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_acc    <= 64'd0;
            r_b      <= 32'd0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_div <= 1'b0;
            r_sgn    <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_accept) begin
                r_acc    <= {32'd0, w_a_mag};
                r_b      <= w_b_mag;
                r_neg_q  <= w_a_neg ^ w_b_neg;
                r_neg_r  <= w_a_neg;
                r_is_div <= is_div;
                r_sgn    <= sgn;
                r_dz     <= is_div & (opb == 32'd0);
                r_cnt    <= 6'd0;
            end else if (r_state == S_RUN) begin
                r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
                r_cnt <= r_cnt + 6'd1;
            end

            if (w_commit) begin
                if (r_is_div) begin
                    r_hi <= w_rem;
                    r_lo <= w_quo;
                end else begin
                    r_hi <= w_prod[63:32];
                    r_lo <= w_prod[31:0];
                end
            end else if (w_wr_ok) begin
                if (hi_we) begin
                    r_hi <= wdata;
                end
                if (lo_we) begin
                    r_lo <= wdata;
                end
            end
        end
    end

    assign hi_o    = r_hi;
    assign lo_o    = r_lo;
    assign stall_o = ~rst & ~flush &
                     (((r_state == S_IDLE) & start) | (r_state == S_RUN));

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_ctrl
// Description : Directed self-checking bench for muldiv_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_div;
    logic        sgn;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        stall_o;

    int errors = 0;
    int checks = 0;
    int n;

    always #5 clk = ~clk;

    muldiv_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .is_div  (is_div),
        .sgn     (sgn),
        .opa     (opa),
        .opb     (opb),
        .flush   (flush),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wdata   (wdata),
        .hi_o    (hi_o),
        .lo_o    (lo_o),
        .stall_o (stall_o)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents an operation and counts stall cycles; returns in the FIX cycle
    // (or wherever stall first drops) with start still asserted.
    task automatic run_op(input logic d, input logic s, input logic [31:0] a,
                          input logic [31:0] b, output int cnt);
        is_div = d;
        sgn    = s;
        opa    = a;
        opb    = b;
        start  = 1'b1;
        cnt    = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (!stall_o) break;
            cnt++;
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b1; is_div = 1'b0; sgn = 1'b0;
        opa = 32'd0; opb = 32'd0; flush = 1'b0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0;
        tick();
        tick();
        #1;
        chk("rst_stall", {63'd0, stall_o}, 64'd0);
        chk("rst_hi", {32'd0, hi_o}, 64'd0);
        chk("rst_lo", {32'd0, lo_o}, 64'd0);

        // First cycle after reset release accepts immediately
        rst = 1'b0;
        run_op(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, n);
        chk("mulu_stall", n, 64'd33);
        tick();
        chk("mulu_hi", {32'd0, hi_o}, 64'hFFFFFFFE);
        chk("mulu_lo", {32'd0, lo_o}, 64'h00000001);
        start = 1'b0;

        run_op(1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, n);
        chk("divs_stall", n, 64'd33);
        tick();
        chk("divs_hi", {32'd0, hi_o}, 64'hFFFFFFFF);
        chk("divs_lo", {32'd0, lo_o}, 64'hFFFFFFFD);
        start = 1'b0;

        hi_we = 1'b1; wdata = 32'h11;
        tick();
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22;
        tick();
        lo_we = 1'b0;
        chk("mthi_hi", {32'd0, hi_o}, 64'h11);
        chk("mtlo_lo", {32'd0, lo_o}, 64'h22);

        run_op(1'b1, 1'b1, 32'h5, 32'd0, n);
        chk("dz_stall", n, 64'd1);
        tick();
        chk("dz_hi", {32'd0, hi_o}, 64'h11);
        chk("dz_lo", {32'd0, lo_o}, 64'h22);
        start = 1'b0;

        // Multiply flushed on its 10th RUN cycle; mthi attempts during RUN
        is_div = 1'b0; sgn = 1'b0; opa = 32'd3; opb = 32'd5; start = 1'b1;
        #1;
        chk("fl_accept_stall", {63'd0, stall_o}, 64'd1);
        tick();
        hi_we = 1'b1; wdata = 32'hDEAD;
        for (int i = 1; i < 10; i++) tick();
        hi_we = 1'b0;
        #1;
        chk("fl_run_stall", {63'd0, stall_o}, 64'd1);
        flush = 1'b1;
        #1;
        chk("fl_flush_stall", {63'd0, stall_o}, 64'd0);
        tick();
        flush = 1'b0; start = 1'b0;
        chk("fl_hi", {32'd0, hi_o}, 64'h11);
        chk("fl_lo", {32'd0, lo_o}, 64'h22);
        hi_we = 1'b1; wdata = 32'hDEAD;
        tick();
        hi_we = 1'b0;
        chk("idle_mthi_hi", {32'd0, hi_o}, 64'hDEAD);
        chk("idle_mthi_lo", {32'd0, lo_o}, 64'h22);

        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234;
        tick();
        hi_we = 1'b0; lo_we = 1'b0;
        chk("both_hi", {32'd0, hi_o}, 64'h1234);
        chk("both_lo", {32'd0, lo_o}, 64'h1234);

        run_op(1'b1, 1'b0, 32'd100, 32'd7, n);
        chk("divu_stall", n, 64'd33);
        tick();
        chk("divu_hi", {32'd0, hi_o}, 64'd2);
        chk("divu_lo", {32'd0, lo_o}, 64'd14);
        start = 1'b0;

        run_op(1'b1, 1'b1, 32'd7, 32'hFFFFFFFE, n);
        tick();
        chk("divs2_hi", {32'd0, hi_o}, 64'h1);
        chk("divs2_lo", {32'd0, lo_o}, 64'hFFFFFFFD);
        start = 1'b0;

        run_op(1'b0, 1'b1, 32'hFFFFFFFD, 32'd5, n);
        tick();
        chk("muls_hi", {32'd0, hi_o}, 64'hFFFFFFFF);
        chk("muls_lo", {32'd0, lo_o}, 64'hFFFFFFF1);
        start = 1'b0;

        // Back-to-back: result visible right after FIX, next op accepted then
        run_op(1'b0, 1'b1, 32'h80000000, 32'h80000000, n);
        chk("mulmin_stall", n, 64'd33);
        tick();
        chk("mulmin_hi", {32'd0, hi_o}, 64'h40000000);
        chk("mulmin_lo", {32'd0, lo_o}, 64'h0);
        run_op(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, n);
        chk("b2b_stall", n, 64'd33);
        tick();
        chk("divmin_hi", {32'd0, hi_o}, 64'h0);
        chk("divmin_lo", {32'd0, lo_o}, 64'h80000000);
        start = 1'b0;

        // Reset in the middle of RUN
        is_div = 1'b0; sgn = 1'b1; opa = 32'hFFFFFFFD; opb = 32'd5; start = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rstrun_stall", {63'd0, stall_o}, 64'd0);
        tick();
        rst = 1'b0; start = 1'b0;
        chk("rstrun_hi", {32'd0, hi_o}, 64'h0);
        chk("rstrun_lo", {32'd0, lo_o}, 64'h0);
        repeat (40) tick();
        chk("rstrun_late_hi", {32'd0, hi_o}, 64'h0);
        chk("rstrun_late_lo", {32'd0, lo_o}, 64'h0);

        run_op(1'b0, 1'b0, 32'h10, 32'h20, n);
        chk("post_rst_stall", n, 64'd33);
        tick();
        start = 1'b0;
        chk("post_rst_hi", {32'd0, hi_o}, 64'h0);
        chk("post_rst_lo", {32'd0, lo_o}, 64'h200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
